// File: rtl/bsg_link_ddr_tx_sched.sv
// Credit-based round-robin scheduler feeding one DDR link channel through a registered output stage.
// Optional statistics counters are enabled by defining BSG_LINK_TX_SCHED_STATS_EN.
module bsg_link_ddr_tx_sched #(
    parameter int NUM_REQ              = 2,
    parameter int WIDTH                = 16,
    parameter int LG_FIFO_DEPTH        = 6,
    parameter int LG_CREDIT_DECIMATION = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       link_enable_i,
    input  logic [NUM_REQ-1:0]         req_v_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]         req_yumi_o,
    output logic                       link_v_o,
    output logic [WIDTH-1:0]           link_data_o,
    input  logic                       link_ready_i,
    input  logic                       token_i,
    output logic [LG_FIFO_DEPTH:0]     credits_o,
    output logic [1:0]                 state_o,
    output logic                       overflow_o
`ifdef BSG_LINK_TX_SCHED_STATS_EN
    ,
    output logic [31:0]                stall_cnt_o,
    output logic [31:0]                flit_cnt_o
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = LG_FIFO_DEPTH + 2;
    localparam logic [CW-1:0]    CRED_MAX_W = CW'(2 ** LG_FIFO_DEPTH);
    localparam logic [CW-2:0]    CRED_FULL  = (CW-1)'(2 ** LG_FIFO_DEPTH);
    localparam logic [CW-1:0]    TOK_INC    = CW'(2 ** LG_CREDIT_DECIMATION);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_DRAIN  = 2'b10
    } state_e;

    state_e             state_r, state_nxt_s;
    logic [CW-2:0]      credits_r, cred_nxt_s;
    logic [CW-1:0]      cred_sum_s;
    logic               ovf_s;
    logic               token_r, tok_evt_s, tok_cnt_s;
    logic [PTR_W-1:0]   rr_ptr_r, win_s, ptr_nxt_s;
    logic               found_s, gnt_s;
    logic [NUM_REQ-1:0] yumi_s;
    logic [WIDTH-1:0]   win_data_s;
    logic               link_v_r;
    logic [WIDTH-1:0]   link_data_r;
    logic               overflow_r;
    int                 dist_s, best_s;

    // Round-robin pick: the requesting index at the smallest forward distance from rr_ptr wins.
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        best_s  = NUM_REQ;
        dist_s  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist_s = (i >= int'(rr_ptr_r)) ? (i - int'(rr_ptr_r)) : (i - int'(rr_ptr_r) + NUM_REQ);
            if (req_v_i[i] && (dist_s < best_s)) begin
                best_s  = dist_s;
                win_s   = PTR_W'(i);
                found_s = 1'b1;
            end else begin
                best_s  = best_s;
            end
        end
    end

    assign tok_evt_s = token_i ^ token_r;
    assign tok_cnt_s = tok_evt_s && (state_r != ST_OFF);
    assign gnt_s     = (state_r == ST_ACTIVE) && link_enable_i && found_s &&
                       (credits_r != '0) && (!link_v_r || link_ready_i);

    // One-hot accept, winning data select and the pointer value after this grant.
    always_comb begin
        yumi_s     = '0;
        win_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_s && (win_s == PTR_W'(i))) begin
                yumi_s[i]  = 1'b1;
                win_data_s = req_data_i[i*WIDTH +: WIDTH];
            end else begin
                yumi_s[i]  = 1'b0;
            end
        end
        ptr_nxt_s = (win_s == PTR_LAST) ? '0 : (win_s + PTR_W'(1));
    end

    // Credit update: grant and returned token net out in one cycle, clamped at the FIFO depth.
    always_comb begin
        cred_sum_s = {1'b0, credits_r} - CW'(gnt_s) + (tok_cnt_s ? TOK_INC : {CW{1'b0}});
        ovf_s      = 1'b0;
        cred_nxt_s = credits_r;
        if (state_r == ST_OFF) begin
            cred_nxt_s = link_enable_i ? CRED_FULL : credits_r;
        end else if (cred_sum_s > CRED_MAX_W) begin
            cred_nxt_s = CRED_FULL;
            ovf_s      = 1'b1;
        end else begin
            cred_nxt_s = cred_sum_s[CW-2:0];
        end
    end

    // Bring-up / drain sequencing; a returning enable during drain resumes without a credit reload.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_OFF: begin
                if (link_enable_i) state_nxt_s = ST_ACTIVE;
                else               state_nxt_s = ST_OFF;
            end
            ST_ACTIVE: begin
                if (!link_enable_i) state_nxt_s = ST_DRAIN;
                else                state_nxt_s = ST_ACTIVE;
            end
            ST_DRAIN: begin
                if (link_enable_i)                              state_nxt_s = ST_ACTIVE;
                else if (!link_v_r && (credits_r == CRED_FULL)) state_nxt_s = ST_OFF;
                else                                            state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_OFF;
        endcase
    end

    // Control state: FSM, credits, token history, round-robin pointer and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_OFF;
            credits_r  <= CRED_FULL;
            token_r    <= 1'b0;
            rr_ptr_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            credits_r <= cred_nxt_s;
            token_r   <= token_i;
            if (gnt_s) rr_ptr_r <= ptr_nxt_s;
            if (ovf_s) overflow_r <= 1'b1;
        end
    end

    // Output register toward the serializer; data holds until the flit is taken or replaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_v_r    <= 1'b0;
            link_data_r <= '0;
        end else if (gnt_s) begin
            link_v_r    <= 1'b1;
            link_data_r <= win_data_s;
        end else if (link_v_r && link_ready_i) begin
            link_v_r    <= 1'b0;
        end
    end

`ifdef BSG_LINK_TX_SCHED_STATS_EN
    logic [31:0] stall_cnt_r, flit_cnt_r;
    logic        enter_active_s;

    assign enter_active_s = (state_r != ST_ACTIVE) && (state_nxt_s == ST_ACTIVE);

    // Credit-starvation and delivered-flit counters, restarted on every entry to ACTIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
            flit_cnt_r  <= 32'd0;
        end else if (enter_active_s) begin
            stall_cnt_r <= 32'd0;
            flit_cnt_r  <= 32'd0;
        end else begin
            if ((state_r == ST_ACTIVE) && (|req_v_i) && (credits_r == '0) &&
                (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (link_v_r && link_ready_i) flit_cnt_r <= flit_cnt_r + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_r;
    assign flit_cnt_o  = flit_cnt_r;
`endif

    assign req_yumi_o  = yumi_s;
    assign link_v_o    = link_v_r;
    assign link_data_o = link_data_r;
    assign credits_o   = credits_r;
    assign state_o     = state_r;
    assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_bsg_link_ddr_tx_sched.sv
// Bench for bsg_link_ddr_tx_sched: directed bring-up/credit/drain scenarios, then randomized traffic,
// all checked every cycle against a behavioural model of the scheduler.
module tb_bsg_link_ddr_tx_sched;

    localparam int N    = 2;
    localparam int W    = 16;
    localparam int LGF  = 6;
    localparam int LGD  = 3;
    localparam int CMAX = 1 << LGF;
    localparam int TINC = 1 << LGD;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           link_enable_i = 1'b0;
    logic [N-1:0]   req_v_i = '0;
    logic [N*W-1:0] req_data_i = '0;
    logic [N-1:0]   req_yumi_o;
    logic           link_v_o;
    logic [W-1:0]   link_data_o;
    logic           link_ready_i = 1'b0;
    logic           token_i = 1'b0;
    logic [LGF:0]   credits_o;
    logic [1:0]     state_o;
    logic           overflow_o;
`ifdef BSG_LINK_TX_SCHED_STATS_EN
    logic [31:0]    stall_cnt_o, flit_cnt_o;
`endif

    always #5 clk = ~clk;

    bsg_link_ddr_tx_sched #(
        .NUM_REQ(N), .WIDTH(W), .LG_FIFO_DEPTH(LGF), .LG_CREDIT_DECIMATION(LGD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .link_enable_i(link_enable_i),
        .req_v_i(req_v_i), .req_data_i(req_data_i), .req_yumi_o(req_yumi_o),
        .link_v_o(link_v_o), .link_data_o(link_data_o), .link_ready_i(link_ready_i),
        .token_i(token_i), .credits_o(credits_o), .state_o(state_o), .overflow_o(overflow_o)
`ifdef BSG_LINK_TX_SCHED_STATS_EN
        , .stall_cnt_o(stall_cnt_o), .flit_cnt_o(flit_cnt_o)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: state 0 OFF, 1 ACTIVE, 2 DRAIN.
    int           m_st, m_cred, m_ptr;
    bit           m_v, m_ov, m_tokp;
    logic [W-1:0] m_d;
    logic [N-1:0] last_yumi;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check DUT outputs against the model, then advance the model.
    task automatic step(input bit en, input logic [N-1:0] rq, input bit rdy, input bit tog);
        int           w, n, nst;
        bit           g, tok;
        logic [N-1:0] ey;
        link_enable_i = en;
        req_v_i       = rq;
        link_ready_i  = rdy;
        if (tog) token_i = ~token_i;
        for (int i = 0; i < N; i++) req_data_i[i*W +: W] = W'($urandom);
        #3;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        g   = (m_st == 1) && en && (w >= 0) && (m_cred != 0) && (!m_v || rdy);
        tok = (token_i != m_tokp);
        ey  = '0;
        if (g) ey[w] = 1'b1;
        chk("yumi", req_yumi_o, ey);
        chk("link_v", link_v_o, m_v);
        chk("link_data", link_data_o, m_d);
        chk("credits", credits_o, m_cred);
        chk("state", state_o, m_st);
        chk("overflow", overflow_o, m_ov);
        last_yumi = req_yumi_o;
        nst = m_st;
        n   = m_cred;
        case (m_st)
            0: if (en) begin nst = 1; n = CMAX; end
            1: begin
                n = m_cred - int'(g) + (tok ? TINC : 0);
                if (!en) nst = 2;
            end
            default: begin
                n = m_cred + (tok ? TINC : 0);
                if (en) nst = 1;
                else if (!m_v && m_cred == CMAX) nst = 0;
            end
        endcase
        if (m_st != 0 && n > CMAX) begin n = CMAX; m_ov = 1'b1; end
        if (g) begin
            m_d   = req_data_i[w*W +: W];
            m_v   = 1'b1;
            m_ptr = (w + 1) % N;
        end else if (m_v && rdy) begin
            m_v = 1'b0;
        end
        m_cred = n;
        m_st   = nst;
        m_tokp = token_i;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset with immediate checks, then a quiet cycle to resynchronise the model.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_link_v", link_v_o, 1'b0);
        chk("rst_credits", credits_o, CMAX);
        chk("rst_state", state_o, 2'b00);
        chk("rst_yumi", req_yumi_o, '0);
        chk("rst_overflow", overflow_o, 1'b0);
        chk("rst_data", link_data_o, '0);
        link_enable_i = 1'b0;
        req_v_i       = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_st = 0; m_cred = CMAX; m_ptr = 0; m_v = 1'b0; m_d = '0; m_ov = 1'b0; m_tokp = token_i;
    endtask

    initial begin
        logic [N-1:0] seq [4];
        logic [N-1:0] exp_seq [4];
        logic [W-1:0] hold;
        int           cnt;
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};

        do_reset();

        // Bring-up and alternating grants.
        step(1'b1, 2'b11, 1'b1, 1'b0);
        chk("bringup_state", state_o, 2'b01);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b11, 1'b1, 1'b0);
            seq[i] = last_yumi;
            if (i == 0) chk("latency_v", link_v_o, 1'b1);
        end
        for (int i = 0; i < 4; i++) chk("rr_order", seq[i], exp_seq[i]);
        chk("credits_60", credits_o, 60);

        // Exhaust credits, then one token returns exactly eight.
        for (int i = 0; i < 100 && m_cred != 0; i++) step(1'b1, 2'b11, 1'b1, 1'b0);
        chk("credits_0", credits_o, 0);
        step(1'b1, 2'b11, 1'b1, 1'b0);
        chk("no_yumi_at_0", last_yumi, 2'b00);
        step(1'b1, 2'b00, 1'b1, 1'b1);
        chk("credits_8", credits_o, 8);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 2'b11, 1'b1, 1'b0);
            cnt += $countones(last_yumi);
        end
        chk("eight_grants", cnt, 8);

        // Grant and token in the same cycle.
        step(1'b1, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 1'b1, 1'b0);
        chk("credits_5", credits_o, 5);
        step(1'b1, 2'b11, 1'b1, 1'b1);
        chk("credits_net_12", credits_o, 12);

        // Back-pressure holds the flit; release drains and reloads in one cycle.
        hold = link_data_o;
        cnt  = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b11, 1'b0, 1'b0);
            cnt += $countones(last_yumi);
        end
        chk("stall_data", link_data_o, hold);
        chk("stall_no_yumi", cnt, 0);
        step(1'b1, 2'b11, 1'b1, 1'b0);
        chk("refill_yumi", $countones(last_yumi), 1);
        chk("refill_v", link_v_o, 1'b1);

        // Drain with credits 40 and a flit pending.
        for (int i = 0; i < 20 && m_cred < 41; i++) step(1'b1, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 20 && m_cred > 40; i++) step(1'b1, 2'b11, 1'b1, 1'b0);
        chk("credits_40", credits_o, 40);
        chk("pending_v", link_v_o, 1'b1);
        step(1'b0, 2'b11, 1'b0, 1'b0);
        chk("drain_state", state_o, 2'b10);
        chk("drain_no_yumi", last_yumi, 2'b00);
        step(1'b0, 2'b11, 1'b0, 1'b0);
        step(1'b0, 2'b11, 1'b1, 1'b0);
        chk("drain_flit_gone", link_v_o, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b1, 1'b1);
        chk("drain_credits_64", credits_o, 64);
        step(1'b0, 2'b00, 1'b1, 1'b0);
        chk("off_state", state_o, 2'b00);

        // Token at full credit overflows.
        step(1'b1, 2'b00, 1'b1, 1'b0);
        step(1'b1, 2'b00, 1'b1, 1'b1);
        chk("ovf_credits", credits_o, 64);
        chk("ovf_flag", overflow_o, 1'b1);

        // Randomized traffic with a reset in the middle.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                step(1'b1, 2'b11, 1'b0, 1'b0);
                do_reset();
            end
            step(($urandom_range(0, 15) != 0), N'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_link_ddr_tx_sched.md
Name: bsg_link_ddr_tx_sched

Overview:
- Credit-based scheduler feeding one DDR link channel from NUM_REQ core-side requesters.
- Round-robin arbitration between requesters; one registered output stage toward the link serializer.
- Tracks remote buffer space with a credit counter. Credits are replenished by the toggle-encoded token returned by the downstream async FIFO.
- Sequences link bring-up and drain with a small state machine.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH, 16, flit width in bits.
- LG_FIFO_DEPTH, 6, log2 of the remote FIFO depth; the maximum credit count is 2^LG_FIFO_DEPTH.
- LG_CREDIT_DECIMATION, 3, each token toggle returns 2^LG_CREDIT_DECIMATION credits.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- link_enable_i  in  1  level; 1 = link trained and usable.
- req_v_i  in  NUM_REQ  per-requester valid.
- req_data_i  in  NUM_REQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_yumi_o  out  NUM_REQ  one-hot accept; data is consumed in the same cycle.
- link_v_o  in/out: out  1  output register valid.
- link_data_o  out  WIDTH  output register data.
- link_ready_i  in  1  serializer takes the flit when link_v_o && link_ready_i.
- token_i  in  1  toggle token, already synchronized to clk.
- credits_o  out  LG_FIFO_DEPTH+1  current credit count.
- state_o  out  2  00 OFF, 01 ACTIVE, 10 DRAIN.
- overflow_o  out  1  sticky: credit return exceeded the maximum.

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - state OFF; credits = 2^LG_FIFO_DEPTH.
  - link_v_o=0, link_data_o=0, req_yumi_o=0, overflow_o=0.
  - Round-robin pointer = 0; token_r = 0.
- Token detection:
  - token_r <= token_i every cycle.
  - tok_evt = token_i ^ token_r.
  - In OFF, tok_evt is ignored and token_r still tracks token_i.
- Grant condition: gnt = (state==ACTIVE) && |req_v_i && credits!=0 && (!link_v_o || link_ready_i).
- Arbitration:
  - Round-robin starting at rr_ptr; the winner gets req_yumi_o[w]=1 combinationally.
  - On a grant: link_data_o <= req_data_i[w], link_v_o <= 1, rr_ptr <= (w+1) mod NUM_REQ.
  - Without a grant, rr_ptr holds.
- Output register:
  - If link_ready_i && link_v_o && !gnt, then link_v_o <= 0.
  - Data holds while link_v_o && !link_ready_i.
  - Latency is 1 cycle from yumi to link_v_o.
  - Back-to-back flits at full rate when credits allow.
- Credit arithmetic, using width LG_FIFO_DEPTH+2 internally:
  - next = credits − gnt + (tok_evt ? 2^LG_CREDIT_DECIMATION : 0).
  - Simultaneous grant and token net out in one cycle.
  - If next > 2^LG_FIFO_DEPTH: clamp to the maximum and set overflow_o (cleared only by reset).
  - The credit count never goes below zero because gnt requires credits!=0.
- State machine:
  - OFF → ACTIVE when link_enable_i=1. On entry to ACTIVE, credits is reloaded to the maximum.
  - ACTIVE → DRAIN when link_enable_i=0. No grant occurs in the transition cycle.
  - DRAIN: no grants. Pending link_v_o still completes on link_ready_i, and tokens are still counted.
  - DRAIN → OFF when !link_v_o && credits==2^LG_FIFO_DEPTH.
  - DRAIN → ACTIVE if link_enable_i returns before draining completes. Credits are kept (no reload).
- Credits==0 in ACTIVE: all req_yumi_o=0, requests remain pending, and rr_ptr holds.
- Wrap-around: rr_ptr wraps from NUM_REQ−1 to 0.
- Reset mid-operation: the in-flight output flit is discarded and no yumi is issued.

Optional Feature:
- Macro BSG_LINK_TX_SCHED_STATS_EN.
- Defined:
  - Adds output stall_cnt_o (32 bits): increments each ACTIVE cycle with |req_v_i && credits==0; saturates at all-ones.
  - Adds output flit_cnt_o (32 bits): increments on each link_v_o && link_ready_i; wraps.
  - Both counters clear on rst_n=0 and on entry to ACTIVE.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then link_enable_i=1 with req_v_i=2'b11 and link_ready_i=1 held: grants alternate 0,1,0,1; link_v_o first high 1 cycle after the first yumi; credits drops 64→60 after 4 grants.
- Defaults, no tokens, 64 flits sent: credits_o=0 and yumi stops. Then toggle token_i once: credits_o=8 next cycle, and exactly 8 more grants follow.
- Grant and token toggle in the same cycle with credits=5: credits_o=12 (5−1+8).
- link_ready_i=0 with link_v_o=1: link_data_o stable and no further yumi. Then ready=1: the flit drains, and a new grant loads in the same cycle.
- link_enable_i drop with credits=40 and a flit pending: state DRAIN, no yumi, flit drains; 3 token toggles give credits 64 → OFF. Also: a 9th toggle at credits 64 in ACTIVE keeps credits at 64 and sets overflow_o=1.
- Assert rst_n=0 mid-transfer: link_v_o=0 and credits=64 immediately (asynchronous); state OFF.
